// File: rtl/vector_fetch_sequencer.sv
// Moore sequencer that fetches a 6502 interrupt/reset vector over the internal
// ADL/ADH buses and loads PC, then jumps by driving PC into the address registers.
module vector_fetch_sequencer #(
    parameter int PRE_CYCLES = 0,
    parameter int CNT_W      = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_vector,
    input  logic       i_rdy,
    output logic       o_0_adl0,
    output logic       o_0_adl1,
    output logic       o_0_adl2,
    output logic       o_dl_adl,
    output logic       o_dl_adh,
    output logic       o_pcl_adl,
    output logic       o_pch_adh,
    output logic       o_pcl_load,
    output logic       o_pch_load,
    output logic       o_ab_load,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        IDLE, DUMMY, VEC_LO, LAT_LO, VEC_HI, LAT_HI, JUMP
    } state_t;

    localparam int B_ADL0 = 11, B_ADL1 = 10, B_ADL2 = 9, B_DLADL = 8, B_DLADH = 7,
                   B_PCLADL = 6, B_PCHADH = 5, B_PCLLD = 4, B_PCHLD = 3,
                   B_ABLD = 2, B_BUSY = 1, B_DONE = 0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;
    logic [11:0]      ctl_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: if (i_start) begin
                vec_d = (i_vector == 2'b11) ? 2'b10 : i_vector;
                if (PRE_CYCLES > 0) begin
                    state_d = DUMMY;
                    cnt_d   = CNT_W'(PRE_CYCLES - 1);
                end else begin
                    state_d = VEC_LO;
                end
            end
            DUMMY: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = VEC_LO;
            end
            VEC_LO:  if (i_rdy) state_d = LAT_LO;
            LAT_LO:  state_d = VEC_HI;
            VEC_HI:  if (i_rdy) state_d = LAT_HI;
            LAT_HI:  state_d = JUMP;
            JUMP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ADL bit0 is pulled only for the low byte; bits 1/2 select RESET/NMI in both reads.
    function automatic logic [11:0] decode(state_t s, logic [1:0] v);
        logic [11:0] c;
        logic        nmi, rst;
        nmi = (v == 2'b00);
        rst = (v == 2'b01);
        c   = '0;
        unique case (s)
            DUMMY:  c[B_BUSY] = 1'b1;
            VEC_LO: begin
                c[B_ADL0] = 1'b1; c[B_ADL1] = rst; c[B_ADL2] = nmi;
                c[B_ABLD] = 1'b1; c[B_BUSY] = 1'b1;
            end
            LAT_LO: begin
                c[B_DLADL] = 1'b1; c[B_PCLLD] = 1'b1; c[B_BUSY] = 1'b1;
            end
            VEC_HI: begin
                c[B_ADL1] = rst; c[B_ADL2] = nmi;
                c[B_ABLD] = 1'b1; c[B_BUSY] = 1'b1;
            end
            LAT_HI: begin
                c[B_DLADH] = 1'b1; c[B_PCHLD] = 1'b1; c[B_BUSY] = 1'b1;
            end
            JUMP: begin
                c[B_PCLADL] = 1'b1; c[B_PCHADH] = 1'b1; c[B_ABLD] = 1'b1;
                c[B_BUSY]   = 1'b1; c[B_DONE]   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= 2'b00;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            ctl_q   <= decode(state_d, vec_d);
        end
    end

    assign o_0_adl0   = ctl_q[B_ADL0];
    assign o_0_adl1   = ctl_q[B_ADL1];
    assign o_0_adl2   = ctl_q[B_ADL2];
    assign o_dl_adl   = ctl_q[B_DLADL];
    assign o_dl_adh   = ctl_q[B_DLADH];
    assign o_pcl_adl  = ctl_q[B_PCLADL];
    assign o_pch_adh  = ctl_q[B_PCHADH];
    assign o_pcl_load = ctl_q[B_PCLLD];
    assign o_pch_load = ctl_q[B_PCHLD];
    assign o_ab_load  = ctl_q[B_ABLD];
    assign o_busy     = ctl_q[B_BUSY];
    assign o_done     = ctl_q[B_DONE];

endmodule

// File: tb/tb_vector_fetch_sequencer.sv
// Directed bench: two sequencers (PRE_CYCLES 0 and 5) plus a bus-routing model for the first.
module tb_vector_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, rdy;
    logic [1:0] vec;
    logic [11:0] o0, o5;   // {adl0,adl1,adl2,dl_adl,dl_adh,pcl_adl,pch_adh,pcl_ld,pch_ld,ab_ld,busy,done}

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    vector_fetch_sequencer #(.PRE_CYCLES(0), .CNT_W(3)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_vector(vec), .i_rdy(rdy),
        .o_0_adl0(o0[11]), .o_0_adl1(o0[10]), .o_0_adl2(o0[9]), .o_dl_adl(o0[8]),
        .o_dl_adh(o0[7]), .o_pcl_adl(o0[6]), .o_pch_adh(o0[5]), .o_pcl_load(o0[4]),
        .o_pch_load(o0[3]), .o_ab_load(o0[2]), .o_busy(o0[1]), .o_done(o0[0]));

    vector_fetch_sequencer #(.PRE_CYCLES(5), .CNT_W(3)) dut5 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_vector(vec), .i_rdy(rdy),
        .o_0_adl0(o5[11]), .o_0_adl1(o5[10]), .o_0_adl2(o5[9]), .o_dl_adl(o5[8]),
        .o_dl_adh(o5[7]), .o_pcl_adl(o5[6]), .o_pch_adh(o5[5]), .o_pcl_load(o5[4]),
        .o_pch_load(o5[3]), .o_ab_load(o5[2]), .o_busy(o5[1]), .o_done(o5[0]));

    // Bus model: open-drain and driven sources wire-AND onto the FF-precharged buses.
    logic [15:0] ab_q = 16'h0000;
    logic [7:0]  pcl_q = 8'h00, pch_q = 8'h00;
    logic [7:0]  adl, adh, dl;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'h78;
            16'hFFFB: return 8'h56;
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'hFFFE: return 8'hBC;
            16'hFFFF: return 8'h9A;
            default:  return 8'h00;
        endcase
    endfunction

    always_comb begin
        dl  = mem_rd(ab_q);
        adl = 8'hFF & ~{5'b0, o0[9], o0[10], o0[11]};
        if (o0[8]) adl = adl & dl;
        if (o0[6]) adl = adl & pcl_q;
        adh = 8'hFF;
        if (o0[7]) adh = adh & dl;
        if (o0[5]) adh = adh & pch_q;
    end

    always @(posedge clk) begin
        if (o0[2]) ab_q  <= {adh, adl};
        if (o0[4]) pcl_q <= adl;
        if (o0[3]) pch_q <= adh;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bus-driver exclusivity on every cycle for both instances.
    always @(negedge clk) begin
        if (o0[1]) begin
            chk("excl_adl0", 32'(int'(|o0[11:9]) + int'(o0[8]) + int'(o0[6]) <= 1), 32'd1);
            chk("excl_adh0", 32'(int'(o0[7]) + int'(o0[5]) <= 1), 32'd1);
        end
        if (o5[1]) begin
            chk("excl_adl5", 32'(int'(|o5[11:9]) + int'(o5[8]) + int'(o5[6]) <= 1), 32'd1);
            chk("excl_adh5", 32'(int'(o5[7]) + int'(o5[5]) <= 1), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((o0[1] || o5[1]) && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(o0[1] || o5[1]), 32'd0);
    endtask

    logic [15:0] ab_lo, ab_hi, jmp_bus;

    // Runs one fetch; returns start-to-done latency and the ADL values of both reads.
    task automatic do_fetch(input bit sel, input logic [1:0] v, input int lo_st, input int hi_st,
                            input int rep, output int lat, output logic [7:0] alo,
                            output logic [7:0] ahi, output bit held);
        logic [11:0] ob, flo, fhi;
        int cyc = 0, nlo = 0, nhi = 0;
        bit seen_lat = 1'b0;
        lat = -1; alo = 8'h00; ahi = 8'h00; held = 1'b1; flo = '0; fhi = '0;
        vec = v; start = 1'b1; rdy = 1'b1;
        step();
        start = 1'b0;
        vec = ~v;
        while (cyc < 40 && lat < 0) begin
            cyc++;
            ob = sel ? o5 : o0;
            rdy = 1'b1;
            start = (rep != 0 && cyc == rep);
            if (ob[2] && !ob[6]) begin
                if (!seen_lat) begin
                    nlo++;
                    if (nlo == 1) begin flo = ob; alo = 8'hFF & ~{5'b0, ob[9], ob[10], ob[11]}; end
                    else if (ob !== flo) held = 1'b0;
                    rdy = (nlo > lo_st);
                end else begin
                    nhi++;
                    if (nhi == 1) begin fhi = ob; ahi = 8'hFF & ~{5'b0, ob[9], ob[10], ob[11]}; end
                    else if (ob !== fhi) held = 1'b0;
                    rdy = (nhi > hi_st);
                end
            end
            if (ob[4]) begin seen_lat = 1'b1; ab_lo = ab_q; end
            if (ob[3]) ab_hi = ab_q;
            if (ob[0]) begin lat = cyc; jmp_bus = {adh, adl}; end
            step();
        end
        start = 1'b0;
        rdy = 1'b1;
    endtask

    int lat;
    logic [7:0] alo, ahi;
    bit held;

    initial begin
        rst = 1'b1; start = 1'b0; rdy = 1'b1; vec = 2'b00;
        // T1: reset and idle
        step(); step();
        chk("rst_out0", 32'(o0), 32'h0);
        chk("rst_out5", 32'(o5), 32'h0);
        rst = 1'b0;
        repeat (5) step();
        chk("idle_out0", 32'(o0), 32'h0);
        chk("idle_busy5", 32'(o5[1]), 32'd0);

        // T2: RESET vector through the routing model
        do_fetch(1'b0, 2'b01, 0, 0, 0, lat, alo, ahi, held);
        chk("t2_lat", 32'(lat), 32'd5);
        chk("t2_adl_lo", 32'(alo), 32'hFC);
        chk("t2_adl_hi", 32'(ahi), 32'hFD);
        chk("t2_ab_lo", 32'(ab_lo), 32'hFFFC);
        chk("t2_ab_hi", 32'(ab_hi), 32'hFFFD);
        chk("t2_jmp_bus", 32'(jmp_bus), 32'h1234);
        chk("t2_pc", 32'({pch_q, pcl_q}), 32'h1234);
        chk("t2_ab_end", 32'(ab_q), 32'h1234);
        chk("t2_idle_after", 32'(o0), 32'h0);
        wait_idle();

        // T3: NMI, IRQ, and 11 aliased to IRQ
        do_fetch(1'b0, 2'b00, 0, 0, 0, lat, alo, ahi, held);
        chk("t3_nmi_lo", 32'(alo), 32'hFA);
        chk("t3_nmi_hi", 32'(ahi), 32'hFB);
        chk("t3_nmi_pc", 32'({pch_q, pcl_q}), 32'h5678);
        wait_idle();
        do_fetch(1'b0, 2'b10, 0, 0, 0, lat, alo, ahi, held);
        chk("t3_irq_lo", 32'(alo), 32'hFE);
        chk("t3_irq_hi", 32'(ahi), 32'hFF);
        chk("t3_irq_pc", 32'({pch_q, pcl_q}), 32'h9ABC);
        wait_idle();
        pcl_q = 8'h00; pch_q = 8'h00;
        do_fetch(1'b0, 2'b11, 0, 0, 0, lat, alo, ahi, held);
        chk("t3_v11_lo", 32'(alo), 32'hFE);
        chk("t3_v11_hi", 32'(ahi), 32'hFF);
        chk("t3_v11_pc", 32'({pch_q, pcl_q}), 32'h9ABC);
        wait_idle();

        // T4: RDY stalls in both read states
        do_fetch(1'b0, 2'b01, 3, 2, 0, lat, alo, ahi, held);
        chk("t4_lat", 32'(lat), 32'd10);
        chk("t4_held", 32'(held), 32'd1);
        chk("t4_adl", 32'({alo, ahi}), 32'hFCFD);
        chk("t4_pc", 32'({pch_q, pcl_q}), 32'h1234);
        wait_idle();

        // T5: dummy cycles and a re-pulsed start while busy
        do_fetch(1'b1, 2'b01, 0, 0, 3, lat, alo, ahi, held);
        chk("t5_lat", 32'(lat), 32'd10);
        chk("t5_adl", 32'({alo, ahi}), 32'hFCFD);
        chk("t5_no_requeue", 32'(o5[1]), 32'd0);
        step();
        chk("t5_still_idle", 32'(o5), 32'h0);
        wait_idle();

        // T6: reset during LAT_LO abandons the fetch
        vec = 2'b01; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t6_in_lat_lo", 32'(o0[8] & o0[4]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_out_zero", 32'(o0), 32'h0);
        begin
            bit pch_seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (o0[3] || o0[1]) pch_seen = 1'b1;
                step();
            end
            chk("t6_no_pch_load", 32'(pch_seen), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
